// File: rtl/sprite_frame_scheduler.sv
// Frame-synchronous sprite register controller: host writes land in shadow
// registers and are committed to the compositor's active registers at vblank start.
module sprite_frame_scheduler #(
  parameter int unsigned NUM_OBJ      = 6,
  parameter int unsigned VACTIVE      = 480,
  parameter int unsigned ANIM_DEFAULT = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 chipselect,
  input  logic                 write,
  input  logic                 read,
  input  logic [8:0]           address,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata,
  input  logic [10:0]          hcount,
  input  logic [9:0]           vcount,
  output logic [8*NUM_OBJ-1:0] obj_x,
  output logic [8*NUM_OBJ-1:0] obj_y,
  output logic [NUM_OBJ-1:0]   obj_en,
  output logic [3:0]           score,
  output logic [1:0]           anim_state,
  output logic                 frame_tick,
  output logic                 commit
);

  localparam int unsigned XY_W    = 8 * NUM_OBJ;
  localparam int unsigned PER_W   = 8;
  localparam int unsigned FCNT_W  = 16;
  localparam int unsigned SCORE_W = 4;
  localparam int unsigned ANIM_W  = 2;

  localparam logic [8:0] ADDR_SCORE  = 9'd12;
  localparam logic [8:0] ADDR_EN     = 9'd13;
  localparam logic [8:0] ADDR_PERIOD = 9'd14;
  localparam logic [8:0] ADDR_CTRL   = 9'd15;
  localparam logic [8:0] ADDR_STATUS = 9'd16;

  // Shadow (host-facing) registers
  logic [XY_W-1:0]    sh_x_q, sh_x_d;
  logic [XY_W-1:0]    sh_y_q, sh_y_d;
  logic [NUM_OBJ-1:0] sh_en_q, sh_en_d;
  logic [SCORE_W-1:0] sh_score_q, sh_score_d;

  // Active (compositor-facing) registers
  logic [XY_W-1:0]    act_x_q, act_x_d;
  logic [XY_W-1:0]    act_y_q, act_y_d;
  logic [NUM_OBJ-1:0] act_en_q, act_en_d;
  logic [SCORE_W-1:0] act_score_q, act_score_d;

  // Control and animation state
  logic [PER_W-1:0]   period_q, period_d;
  logic [PER_W-1:0]   div_q, div_d;
  logic [ANIM_W-1:0]  anim_q, anim_d;
  logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
  logic               lock_q, lock_d;
  logic               pending_q, pending_d;
  logic               tick_q, tick_d;
  logic               commit_q, commit_d;
  logic [31:0]        rdata_q, rdata_d;

  logic wr_c;
  logic rd_c;
  logic frame_start_c;
  logic do_commit_c;
  logic unused_wdata_c;

  assign wr_c          = chipselect & write;
  assign rd_c          = chipselect & read;
  assign frame_start_c = (hcount == 11'd0) && (vcount == 10'(VACTIVE));
  assign do_commit_c   = frame_start_c & pending_q & ~lock_q;
  assign unused_wdata_c = ^writedata[31:8];

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_x_q      <= '0;
      sh_y_q      <= '0;
      sh_en_q     <= '1;
      sh_score_q  <= '0;
      act_x_q     <= '0;
      act_y_q     <= '0;
      act_en_q    <= '1;
      act_score_q <= '0;
      period_q    <= PER_W'(ANIM_DEFAULT);
      div_q       <= '0;
      anim_q      <= '0;
      fcnt_q      <= '0;
      lock_q      <= 1'b0;
      pending_q   <= 1'b0;
      tick_q      <= 1'b0;
      commit_q    <= 1'b0;
      rdata_q     <= '0;
    end else begin
      sh_x_q      <= sh_x_d;
      sh_y_q      <= sh_y_d;
      sh_en_q     <= sh_en_d;
      sh_score_q  <= sh_score_d;
      act_x_q     <= act_x_d;
      act_y_q     <= act_y_d;
      act_en_q    <= act_en_d;
      act_score_q <= act_score_d;
      period_q    <= period_d;
      div_q       <= div_d;
      anim_q      <= anim_d;
      fcnt_q      <= fcnt_d;
      lock_q      <= lock_d;
      pending_q   <= pending_d;
      tick_q      <= tick_d;
      commit_q    <= commit_d;
      rdata_q     <= rdata_d;
    end
  end

  // Frame-start commit, animation divider and host writes
  always_comb begin
    sh_x_d      = sh_x_q;
    sh_y_d      = sh_y_q;
    sh_en_d     = sh_en_q;
    sh_score_d  = sh_score_q;
    act_x_d     = act_x_q;
    act_y_d     = act_y_q;
    act_en_d    = act_en_q;
    act_score_d = act_score_q;
    period_d    = period_q;
    div_d       = div_q;
    anim_d      = anim_q;
    fcnt_d      = fcnt_q;
    lock_d      = lock_q;
    pending_d   = pending_q;
    tick_d      = frame_start_c;
    commit_d    = do_commit_c;

    if (frame_start_c) begin
      fcnt_d = fcnt_q + FCNT_W'(1);
      if (period_q != '0) begin
        if (div_q >= period_q) begin
          div_d = '0;
        end else if (div_q == period_q - PER_W'(1)) begin
          div_d  = '0;
          anim_d = (anim_q == ANIM_W'(2)) ? '0 : anim_q + ANIM_W'(1);
        end else begin
          div_d = div_q + PER_W'(1);
        end
      end
    end

    // Commit copies the pre-edge shadow; a coincident write lands afterwards.
    if (do_commit_c) begin
      act_x_d     = sh_x_q;
      act_y_d     = sh_y_q;
      act_en_d    = sh_en_q;
      act_score_d = sh_score_q;
      pending_d   = 1'b0;
    end

    if (wr_c) begin
      for (int unsigned k = 0; k < NUM_OBJ; k++) begin
        if (address == 9'(2 * k)) begin
          sh_x_d[8*k +: 8] = writedata[7:0];
        end
        if (address == 9'(2 * k + 1)) begin
          sh_y_d[8*k +: 8] = writedata[7:0];
        end
      end
      case (address)
        ADDR_SCORE:  sh_score_d = writedata[SCORE_W-1:0];
        ADDR_EN:     sh_en_d    = writedata[NUM_OBJ-1:0];
        ADDR_PERIOD: begin
          period_d = writedata[PER_W-1:0];
          div_d    = '0;
        end
        ADDR_CTRL:   lock_d     = writedata[0];
        default: ;
      endcase
      if (address < ADDR_PERIOD) begin
        pending_d = 1'b1;
      end
    end
  end

  // Registered read mux; readdata holds between reads
  always_comb begin
    rdata_d = rdata_q;
    if (rd_c) begin
      rdata_d = '0;
      for (int unsigned k = 0; k < NUM_OBJ; k++) begin
        if (address == 9'(2 * k)) begin
          rdata_d = 32'(sh_x_q[8*k +: 8]);
        end
        if (address == 9'(2 * k + 1)) begin
          rdata_d = 32'(sh_y_q[8*k +: 8]);
        end
      end
      case (address)
        ADDR_SCORE:  rdata_d = 32'(sh_score_q);
        ADDR_EN:     rdata_d = 32'(sh_en_q);
        ADDR_PERIOD: rdata_d = 32'(period_q);
        ADDR_CTRL:   rdata_d = 32'(lock_q);
        ADDR_STATUS: rdata_d = {fcnt_q, 12'd0, anim_q, lock_q, pending_q};
        default: ;
      endcase
    end
  end

  assign readdata   = rdata_q;
  assign obj_x      = act_x_q;
  assign obj_y      = act_y_q;
  assign obj_en     = act_en_q;
  assign score      = act_score_q;
  assign anim_state = anim_q;
  assign frame_tick = tick_q;
  assign commit     = commit_q;

endmodule

// File: tb/tb_sprite_frame_scheduler.sv
// Directed bench for sprite_frame_scheduler: register table plus frame-level
// sequences for deferred commit, lock, collision, animation and async reset.
module tb_sprite_frame_scheduler;

  logic        clk;
  logic        reset;
  logic        chipselect;
  logic        write;
  logic        read;
  logic [8:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [47:0] obj_x;
  logic [47:0] obj_y;
  logic [5:0]  obj_en;
  logic [3:0]  score;
  logic [1:0]  anim_state;
  logic        frame_tick;
  logic        commit;

  int checks = 0;
  int errors = 0;

  sprite_frame_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .chipselect (chipselect),
    .write      (write),
    .read       (read),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata),
    .hcount     (hcount),
    .vcount     (vcount),
    .obj_x      (obj_x),
    .obj_y      (obj_y),
    .obj_en     (obj_en),
    .score      (score),
    .anim_state (anim_state),
    .frame_tick (frame_tick),
    .commit     (commit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    chipselect = 1'b0;
    write      = 1'b0;
    read       = 1'b0;
    hcount     = 11'd5;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [8:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write      = 1'b1;
    address    = a;
    writedata  = d;
    step();
    chipselect = 1'b0;
    write      = 1'b0;
  endtask

  task automatic bus_read(input logic [8:0] a, output logic [31:0] d);
    chipselect = 1'b1;
    read       = 1'b1;
    address    = a;
    step();
    chipselect = 1'b0;
    read       = 1'b0;
    d          = readdata;
  endtask

  task automatic frame();
    hcount = 11'd0;
    vcount = 10'd480;
    step();
    hcount = 11'd5;
    vcount = 10'd100;
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    #1;
  endtask

  logic [31:0] rd;
  logic [1:0]  anim_exp [7];

  initial begin
    vecs[0] = '{9'd0,   32'hDEAD_BE64, 32'h0000_0064};
    vecs[1] = '{9'd3,   32'h0000_01FF, 32'h0000_00FF};
    vecs[2] = '{9'd11,  32'h0000_00A5, 32'h0000_00A5};
    vecs[3] = '{9'd12,  32'hFFFF_FFF7, 32'h0000_0007};
    vecs[4] = '{9'd13,  32'h0000_00C5, 32'h0000_0005};
    vecs[5] = '{9'd14,  32'h1234_0003, 32'h0000_0003};
    vecs[6] = '{9'd15,  32'hFFFF_FFFE, 32'h0000_0000};
    vecs[7] = '{9'd100, 32'h0000_0055, 32'h0000_0000};
    vecs[8] = '{9'd17,  32'h0000_0077, 32'h0000_0000};
    vecs[9] = '{9'd16,  32'hFFFF_FFFF, 32'h0000_0001};
    anim_exp = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0};

    reset = 1'b1;
    address = '0;
    writedata = '0;
    vcount = 10'd100;
    idle();
    repeat (2) step();
    reset = 1'b0;
    step();

    // Reset values
    check("rst_obj_x", 32'(obj_x[31:0]), 32'h0);
    check("rst_obj_y", 32'(obj_y[31:0]), 32'h0);
    check("rst_obj_en", 32'(obj_en), 32'h3F);
    check("rst_anim", 32'(anim_state), 32'h0);
    check("rst_pulses", {30'd0, commit, frame_tick}, 32'h0);
    check("rst_readdata", readdata, 32'h0);
    bus_read(9'd16, rd);
    check("rst_status", rd, 32'h0);

    // Register table: write then read back
    for (int i = 0; i < 10; i++) begin
      bus_write(vecs[i].addr, vecs[i].wdata);
      bus_read(vecs[i].addr, rd);
      check($sformatf("reg_rd_%0d", vecs[i].addr), rd, vecs[i].exp_rd);
    end
    step();
    check("rd_hold", readdata, 32'h1);
    check("pre_commit_x", 32'(obj_x[7:0]), 32'h0);
    frame();
    check("tbl_commit", 32'(commit), 32'h1);
    check("tbl_obj_x0", 32'(obj_x[7:0]), 32'h64);
    check("tbl_obj_y1", 32'(obj_y[15:8]), 32'hFF);
    check("tbl_obj_y5", 32'(obj_y[47:40]), 32'hA5);
    check("tbl_obj_en", 32'(obj_en), 32'h05);
    check("tbl_score", 32'(score), 32'h7);

    pulse_reset();
    step();

    // Deferred commit
    vcount = 10'd100;
    bus_write(9'd0, 32'h64);
    repeat (3) step();
    check("defer_hold_x", 32'(obj_x[7:0]), 32'h0);
    bus_read(9'd16, rd);
    check("defer_pending", rd, 32'h0000_0001);
    frame();
    check("defer_x", 32'(obj_x[7:0]), 32'h64);
    check("defer_commit", 32'(commit), 32'h1);
    check("defer_tick", 32'(frame_tick), 32'h1);
    step();
    check("defer_pulse_end", {30'd0, commit, frame_tick}, 32'h0);
    bus_read(9'd16, rd);
    check("defer_status", rd, 32'h0001_0000);

    // Lock suppresses commits
    bus_write(9'd15, 32'h1);
    bus_write(9'd1, 32'h50);
    for (int i = 0; i < 2; i++) begin
      frame();
      check("lock_no_commit", 32'(commit), 32'h0);
      check("lock_y", 32'(obj_y[7:0]), 32'h0);
    end
    bus_read(9'd16, rd);
    check("lock_status", rd, 32'h0003_0003);
    bus_write(9'd15, 32'h0);
    frame();
    check("unlock_commit", 32'(commit), 32'h1);
    check("unlock_y", 32'(obj_y[7:0]), 32'h50);

    // Write coincident with frame start
    bus_write(9'd2, 32'h11);
    hcount = 11'd0;
    vcount = 10'd480;
    chipselect = 1'b1;
    write = 1'b1;
    address = 9'd2;
    writedata = 32'h22;
    step();
    idle();
    vcount = 10'd100;
    check("coll_first", 32'(obj_x[15:8]), 32'h11);
    check("coll_commit", 32'(commit), 32'h1);
    bus_read(9'd16, rd);
    check("coll_pending", rd & 32'h1, 32'h1);
    frame();
    check("coll_second", 32'(obj_x[15:8]), 32'h22);
    bus_read(9'd16, rd);
    check("coll_status", rd, 32'h0006_0004);

    // Async reset mid-frame
    bus_write(9'd4, 32'h33);
    bus_write(9'd13, 32'h0);
    frame();
    check("ar_pre_x", 32'(obj_x[23:16]), 32'h33);
    check("ar_pre_en", 32'(obj_en), 32'h0);
    bus_write(9'd5, 32'h44);
    vcount = 10'd300;
    #2 reset = 1'b1;
    #1;
    check("ar_obj_x", 32'(obj_x[31:0]), 32'h0);
    check("ar_obj_en", 32'(obj_en), 32'h3F);
    check("ar_anim", 32'(anim_state), 32'h0);
    check("ar_readdata", readdata, 32'h0);
    #1 reset = 1'b0;
    #1;
    step();
    bus_read(9'd16, rd);
    check("ar_status", rd, 32'h0);
    frame();
    check("ar_no_commit", 32'(commit), 32'h0);
    bus_write(9'd6, 32'h9);
    frame();
    check("ar_commit", 32'(commit), 32'h1);
    check("ar_y3", 32'(obj_y[31:24]), 32'h0);
    check("ar_x3", 32'(obj_x[31:24]), 32'h9);

    // Animation period 2
    bus_write(9'd14, 32'h2);
    check("anim_0", 32'(anim_state), 32'(anim_exp[0]));
    for (int i = 1; i < 7; i++) begin
      frame();
      check($sformatf("anim_%0d", i), 32'(anim_state), 32'(anim_exp[i]));
    end
    frame();
    frame();
    check("anim_8", 32'(anim_state), 32'h1);
    bus_write(9'd14, 32'h0);
    for (int i = 0; i < 3; i++) begin
      frame();
      check("anim_frozen", 32'(anim_state), 32'h1);
    end
    bus_write(9'd14, 32'h1);
    frame();
    check("anim_p1_a", 32'(anim_state), 32'h2);
    frame();
    check("anim_p1_b", 32'(anim_state), 32'h0);

    // Frame counter wrap (frame start held every cycle)
    pulse_reset();
    hcount = 11'd0;
    vcount = 10'd480;
    repeat (65535) step();
    hcount = 11'd5;
    vcount = 10'd100;
    bus_read(9'd16, rd);
    check("fcnt_ffff", rd, 32'hFFFF_0008);
    frame();
    bus_read(9'd16, rd);
    check("fcnt_wrap", rd, 32'h0000_0008);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
